// File: rtl/crc_rx_check.sv
// crc_rx_check
//   Receive-side CRC checker for the de-stuffed serial stream that follows
//   the PID. Bits arrive LSB-first. Each packet runs either CRC5 (token) or
//   CRC16 (data). At end of packet the register is compared with the protocol
//   residual and the bit count is checked against the length rules. One
//   registered verdict is reported per packet.
//
// Ports
//   clk_c      in   clock
//   reset_n    in   asynchronous active-low reset
//   halt_rx    in   1 = stall; nothing is sampled or updated this cycle
//   pkt_start  in   pulse: a new packet begins with the next bit
//   crc_sel    in   0 = CRC5, 1 = CRC16; sampled with pkt_start
//   data_in    in   serial data bit, consumed in RUN
//   pkt_end    in   pulse after the last CRC bit; data_in ignored that cycle
//   busy       out  1 while a packet is being received
//   done       out  one-cycle (un-halted) verdict strobe
//   crc_ok     out  residual matched; held until the next packet start
//   crc_err    out  residual mismatch; held until the next packet start
//   len_err    out  length rule violated; held until the next packet start
//   bit_cnt    out  bits consumed in the current/last packet (saturating)
//   crc_int    out  live CRC register, CRC5 zero-extended in [4:0]
module crc_rx_check #(
  parameter int CNT_W = 14
) (
  input  logic             clk_c,
  input  logic             reset_n,
  input  logic             halt_rx,
  input  logic             pkt_start,
  input  logic             crc_sel,
  input  logic             data_in,
  input  logic             pkt_end,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             len_err,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [15:0]      crc_int
);

  localparam logic [4:0]  POLY5  = 5'b00101;
  localparam logic [4:0]  INIT5  = 5'h1F;
  localparam logic [4:0]  RES5   = 5'b01100;
  localparam logic [15:0] POLY16 = 16'h8005;
  localparam logic [15:0] INIT16 = 16'hFFFF;
  localparam logic [15:0] RES16  = 16'h800D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  logic   sel;        // CRC width latched for the packet in progress
  logic   res_match;

  // One serial LFSR step; MSB-side feedback with the selected polynomial.
  function automatic logic [15:0] crc_step(input logic [15:0] crc,
                                           input logic        sel16,
                                           input logic        bit_in);
    logic        fb;
    logic [15:0] nxt;
    if (sel16) begin
      fb  = bit_in ^ crc[15];
      nxt = {crc[14:0], 1'b0} ^ (fb ? POLY16 : 16'h0000);
    end else begin
      fb  = bit_in ^ crc[4];
      nxt = {11'h000, crc[3:0], 1'b0} ^ {11'h000, (fb ? POLY5 : 5'h00)};
    end
    return nxt;
  endfunction

  // Counter sticks at all-ones so an overlong packet can never wrap back
  // into a legal length.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  // Token: exactly 11 payload bits + 5 CRC bits. Data: whole bytes, at least
  // the 16 CRC bits. A saturated counter is always a length error.
  function automatic logic len_bad(input logic             sel16,
                                   input logic [CNT_W-1:0] cnt);
    logic bad;
    if (&cnt)
      bad = 1'b1;
    else if (sel16)
      bad = (cnt < CNT_W'(16)) || (cnt[2:0] != 3'd0);
    else
      bad = (cnt != CNT_W'(16));
    return bad;
  endfunction

  assign res_match = sel ? (crc_int == RES16) : (crc_int[4:0] == RES5);

  always_ff @(posedge clk_c or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      sel     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      crc_ok  <= 1'b0;
      crc_err <= 1'b0;
      len_err <= 1'b0;
      bit_cnt <= '0;
      crc_int <= 16'h0000;
    end else if (!halt_rx) begin
      done <= 1'b0;
      // A start is honoured in every state: it begins a packet from IDLE,
      // aborts one in RUN (winning over pkt_end), and follows the verdict
      // cycle in DONE.
      if (pkt_start) begin
        state   <= RUN;
        sel     <= crc_sel;
        busy    <= 1'b1;
        crc_ok  <= 1'b0;
        crc_err <= 1'b0;
        len_err <= 1'b0;
        bit_cnt <= '0;
        crc_int <= crc_sel ? INIT16 : {11'h000, INIT5};
      end else begin
        unique case (state)
          IDLE: begin
            state <= IDLE;
          end
          RUN: begin
            if (pkt_end) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              crc_ok  <= res_match;
              crc_err <= !res_match;
              len_err <= len_bad(sel, bit_cnt);
            end else begin
              crc_int <= crc_step(crc_int, sel, data_in);
              bit_cnt <= sat_inc(bit_cnt);
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crc_rx_check.sv
// tb_crc_rx_check
//   Randomised scoreboard bench for crc_rx_check. The reference model treats
//   each packet as a polynomial and obtains the residual by GF(2) long
//   division; expected verdicts are queued when pkt_end is issued and a
//   separate monitor pops them whenever the DUT strobes done.
module tb_crc_rx_check;

  localparam int CNT_W = 14;
  localparam int MAXB  = 256;

  logic             clk_c;
  logic             reset_n;
  logic             halt_rx;
  logic             pkt_start;
  logic             crc_sel;
  logic             data_in;
  logic             pkt_end;
  logic             busy;
  logic             done;
  logic             crc_ok;
  logic             crc_err;
  logic             len_err;
  logic [CNT_W-1:0] bit_cnt;
  logic [15:0]      crc_int;

  crc_rx_check #(.CNT_W(CNT_W)) dut (
    .clk_c    (clk_c),
    .reset_n  (reset_n),
    .halt_rx  (halt_rx),
    .pkt_start(pkt_start),
    .crc_sel  (crc_sel),
    .data_in  (data_in),
    .pkt_end  (pkt_end),
    .busy     (busy),
    .done     (done),
    .crc_ok   (crc_ok),
    .crc_err  (crc_err),
    .len_err  (len_err),
    .bit_cnt  (bit_cnt),
    .crc_int  (crc_int)
  );

  typedef struct packed {
    logic             ok;
    logic             err;
    logic             len;
    logic [CNT_W-1:0] cnt;
  } verdict_t;

  verdict_t sb[$];
  int       n_checks = 0;
  int       n_fail   = 0;
  bit       halt_en  = 0;
  bit       pkt_bits [0:MAXB-1];

  initial begin
    clk_c = 1'b0;
    forever #5 clk_c = ~clk_c;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Remainder of (init * x^n + M(x) * x^w) mod G, with the first stream bit
  // as the highest-degree coefficient of M.
  function automatic logic [15:0] poly_rem(input bit sel, input int n);
    int          w;
    logic [16:0] g;
    bit          a [0:MAXB+15];
    logic [15:0] r;
    w = sel ? 16 : 5;
    g = sel ? 17'h18005 : 17'h00025;
    for (int i = 0; i < n + w; i++) a[i] = (i < n) ? pkt_bits[i] : 1'b0;
    for (int i = 0; i < w; i++) a[i] = ~a[i];
    for (int i = 0; i < n; i++)
      if (a[i])
        for (int j = 0; j <= w; j++) a[i+j] = a[i+j] ^ g[w-j];
    r = 16'h0000;
    for (int j = 0; j < w; j++) r[w-1-j] = a[n+j];
    return r;
  endfunction

  // Appends the complemented payload remainder, MSB first, giving a packet
  // whose full remainder is the protocol residual.
  function automatic int build_valid(input bit sel, input int pn);
    int          w;
    logic [15:0] r;
    w = sel ? 16 : 5;
    r = poly_rem(sel, pn);
    for (int j = 0; j < w; j++) pkt_bits[pn+j] = ~r[w-1-j];
    return pn + w;
  endfunction

  // Presents one set of inputs and holds it until an un-halted edge takes it.
  task automatic step(input logic ps, input logic sel, input logic d, input logic pe);
    pkt_start = ps;
    crc_sel   = sel;
    data_in   = d;
    pkt_end   = pe;
    do begin
      halt_rx = halt_en ? ($urandom_range(1, 0) == 1) : 1'b0;
      @(posedge clk_c);
      #1;
    end while (halt_rx);
    pkt_start = 1'b0;
    pkt_end   = 1'b0;
    data_in   = 1'b0;
    halt_rx   = 1'b0;
  endtask

  task automatic send_bits(input bit sel, input int n);
    step(1'b1, sel, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) step(1'b0, sel, pkt_bits[i], 1'b0);
  endtask

  task automatic end_pkt(input bit sel, input int n);
    verdict_t    v;
    logic [15:0] r;
    bit          len_good;
    r        = poly_rem(sel, n);
    len_good = sel ? (n >= 16 && (n % 8) == 0) : (n == 16);
    v.ok     = sel ? (r == 16'h800D) : (r == 16'h000C);
    v.err    = !v.ok;
    v.len    = !len_good;
    v.cnt    = CNT_W'(n);
    sb.push_back(v);
    step(1'b0, sel, 1'b0, 1'b1);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load_token(input bit flip12);
    for (int i = 0; i < 16; i++) pkt_bits[i] = 1'b0;
    pkt_bits[12] = flip12 ? 1'b0 : 1'b1;
  endtask

  // Monitor: a verdict is consumed on each un-halted cycle with done high.
  initial begin
    verdict_t e;
    forever begin
      @(negedge clk_c);
      if (reset_n && done && !halt_rx) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no verdict");
        end else begin
          e = sb.pop_front();
          chk("crc_ok",  {31'h0, crc_ok},  {31'h0, e.ok});
          chk("crc_err", {31'h0, crc_err}, {31'h0, e.err});
          chk("len_err", {31'h0, len_err}, {31'h0, e.len});
          chk("bit_cnt", {18'h0, bit_cnt}, {18'h0, e.cnt});
          chk("busy_in_done", {31'h0, busy}, 32'h0);
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},    {31'h0, busy},    32'h0);
    chk({tag, "_done"},    {31'h0, done},    32'h0);
    chk({tag, "_crc_ok"},  {31'h0, crc_ok},  32'h0);
    chk({tag, "_crc_err"}, {31'h0, crc_err}, 32'h0);
    chk({tag, "_len_err"}, {31'h0, len_err}, 32'h0);
    chk({tag, "_bit_cnt"}, {18'h0, bit_cnt}, 32'h0);
    chk({tag, "_crc_int"}, {16'h0, crc_int}, 32'h0);
  endtask

  initial begin
    int n;
    int pn;
    bit sel;
    reset_n   = 1'b0;
    halt_rx   = 1'b0;
    pkt_start = 1'b0;
    crc_sel   = 1'b0;
    data_in   = 1'b0;
    pkt_end   = 1'b0;
    repeat (3) @(posedge clk_c);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;
    idle(2);

    // Known-good token
    load_token(1'b0);
    send_bits(1'b0, 16);
    end_pkt(1'b0, 16);
    chk("t1_crc_int", {16'h0, crc_int}, 32'h0000_000C);
    idle(2);

    // Token with one corrupted bit
    load_token(1'b1);
    send_bits(1'b0, 16);
    end_pkt(1'b0, 16);
    idle(2);

    // Zero-length data packet, then one bit too many
    for (int i = 0; i < 17; i++) pkt_bits[i] = 1'b0;
    send_bits(1'b1, 16);
    end_pkt(1'b1, 16);
    idle(1);
    send_bits(1'b1, 17);
    end_pkt(1'b1, 17);
    idle(2);

    // Token with random stalls
    halt_en = 1;
    load_token(1'b0);
    send_bits(1'b0, 16);
    end_pkt(1'b0, 16);
    idle(4);
    halt_en = 0;

    // Data packet aborted after 7 bits by a new token
    for (int i = 0; i < 7; i++) pkt_bits[i] = 1'($urandom_range(1, 0));
    send_bits(1'b1, 7);
    load_token(1'b0);
    send_bits(1'b0, 16);
    end_pkt(1'b0, 16);
    idle(2);

    // pkt_end while idle is ignored
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // pkt_start together with pkt_end: restart, no verdict
    load_token(1'b0);
    send_bits(1'b0, 10);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, pkt_bits[i], 1'b0);
    end_pkt(1'b0, 16);

    // Back-to-back: start in the verdict cycle; then empty packet
    send_bits(1'b1, 0);
    end_pkt(1'b1, 0);
    idle(2);

    // Reset in the middle of a token
    load_token(1'b0);
    send_bits(1'b0, 9);
    reset_n = 1'b0;
    #1;
    chk_zero("midreset");
    @(posedge clk_c);
    #1;
    reset_n = 1'b1;
    idle(1);
    send_bits(1'b0, 16);
    end_pkt(1'b0, 16);
    idle(2);

    // Randomised packets
    for (int k = 0; k < 40; k++) begin
      sel     = 1'($urandom_range(1, 0));
      halt_en = ($urandom_range(3, 0) == 0);
      if (sel == 1'b0)
        pn = ($urandom_range(3, 0) != 0) ? 11 : int'($urandom_range(14, 0));
      else
        pn = ($urandom_range(3, 0) != 0) ? 8 * int'($urandom_range(8, 0))
                                          : int'($urandom_range(60, 0));
      for (int i = 0; i < MAXB; i++) pkt_bits[i] = 1'($urandom_range(1, 0));
      if ($urandom_range(3, 0) != 0) n = build_valid(sel, pn);
      else n = pn + (sel ? 16 : 5);
      send_bits(sel, n);
      end_pkt(sel, n);
      idle(int'($urandom_range(2, 0)));
    end
    halt_en = 0;
    idle(5);

    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
